// File: rtl/otter_rfile_wb_arbiter.sv
// Write-port arbiter for otter_rfile: the in-order writeback path always wins, and long-latency
// completions queue in a small FIFO. It also holds the pending-write scoreboard that decode queries.
module otter_rfile_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int SEC_DEPTH  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p_wen,
  input  logic [4:0]      p_waddr,
  input  logic [XLEN-1:0] p_wdata,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [4:0]      s_waddr,
  input  logic [XLEN-1:0] s_wdata,
  input  logic            issue_en,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      chk_addr1,
  input  logic [4:0]      chk_addr2,
  output logic            chk_busy1,
  output logic            chk_busy2,
  output logic [31:0]     busy_vec,
  output logic            stall_req,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int PW = (SEC_DEPTH > 1) ? $clog2(SEC_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX) + 1;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } sec_entry_t;

  sec_entry_t      fifo_q [SEC_DEPTH];
  sec_entry_t      fifo_d [SEC_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            stall_req_q, stall_req_d;
  logic            rf_wen_q, rf_wen_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            rf_src_sec_q, rf_src_sec_d;
  logic [31:0]     busy_q, busy_d;

  logic fifo_full, fifo_empty;
  logic p_eff, push, pop, head_blocked, starve_hit;

  assign fifo_full    = (count_q == CW'(SEC_DEPTH));
  assign fifo_empty   = (count_q == '0);
  assign p_eff        = p_wen && (p_waddr != 5'd0);
  assign s_ready      = !rst && !fifo_full;
  // Writes to x0 complete the handshake but never occupy a FIFO slot.
  assign push         = s_valid && s_ready && (s_waddr != 5'd0);
  assign pop          = !p_eff && !fifo_empty;
  assign head_blocked = !fifo_empty && !pop;
  assign starve_hit   = (starve_q == SW'(STARVE_MAX - 1));

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{addr: s_waddr, data: s_wdata};
      wr_ptr_d         = wr_ptr_q + PW'(1);
      count_d          = count_d + CW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      count_d  = count_d - CW'(1);
    end
  end

  always_comb begin
    starve_d    = '0;
    stall_req_d = stall_req_q;
    if (head_blocked) begin
      starve_d = starve_hit ? starve_q : starve_q + SW'(1);
      if (starve_hit) stall_req_d = 1'b1;
    end else if (pop && (count_d == '0)) begin
      stall_req_d = 1'b0;
    end
  end

  always_comb begin
    rf_wen_d     = 1'b0;
    rf_src_sec_d = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    if (p_eff) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = p_waddr;
      rf_wdata_d = p_wdata;
    end else if (pop) begin
      rf_wen_d     = 1'b1;
      rf_src_sec_d = 1'b1;
      rf_waddr_d   = fifo_q[rd_ptr_q].addr;
      rf_wdata_d   = fifo_q[rd_ptr_q].data;
    end
  end

  // Clear is applied before set, so a same-edge reissue of the retiring rd stays busy.
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q && rf_src_sec_q) busy_d[rf_waddr_q] = 1'b0;
    if (issue_en && (issue_rd != 5'd0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      stall_req_q  <= 1'b0;
      rf_wen_q     <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      rf_src_sec_q <= 1'b0;
      busy_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      stall_req_q  <= stall_req_d;
      rf_wen_q     <= rf_wen_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      rf_src_sec_q <= rf_src_sec_d;
      busy_q       <= busy_d;
    end
  end

  assign busy_vec  = busy_q;
  assign chk_busy1 = busy_q[chk_addr1];
  assign chk_busy2 = busy_q[chk_addr2];
  assign stall_req = stall_req_q;
  assign rf_wen    = rf_wen_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;

endmodule

// File: doc/otter_rfile_wb_arbiter.md
Name: otter_rfile_wb_arbiter

Overview:
- Shares the single write port of otter_rfile between two writers.
  - Primary: in-order pipeline writeback. Never stalled by the arbiter.
  - Secondary: long-latency unit completions (div/mul/load). Uses a valid/ready handshake and is buffered in a small FIFO.
- Holds the pending-write scoreboard. Decode uses it to detect RAW/WAW hazards on long-latency destinations.
- Sits between the writeback stage, the long-latency units and the rfile w_en/w_addr/w_data inputs.

Parameters:
- XLEN, 32, data width.
- SEC_DEPTH, 2, secondary FIFO entries; power of two, at least 2.
- STARVE_MAX, 4, consecutive blocked cycles of a non-empty FIFO head before stall_req asserts.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- p_wen  in  1  primary write request
- p_waddr  in  5  primary destination
- p_wdata  in  XLEN  primary data
- s_valid  in  1  secondary write valid
- s_ready  out  1  secondary accept; equals !fifo_full, and is 0 while rst is high
- s_waddr  in  5  secondary destination
- s_wdata  in  XLEN  secondary data
- issue_en  in  1  a long-latency op issues this cycle
- issue_rd  in  5  its destination register
- chk_addr1  in  5  scoreboard query, port 1
- chk_addr2  in  5  scoreboard query, port 2
- chk_busy1  out  1  combinational: busy[chk_addr1]
- chk_busy2  out  1  combinational: busy[chk_addr2]
- busy_vec  out  32  scoreboard state; bit 0 is always 0
- stall_req  out  1  registered; asks the pipeline to bubble writeback
- rf_wen  out  1  registered, to otter_rfile w_en
- rf_waddr  out  5  registered, to otter_rfile w_addr
- rf_wdata  out  XLEN  registered, to otter_rfile w_data

Behaviour:
- Reset: FIFO emptied and any pending entries discarded; busy_vec=0; rf_wen=0; rf_waddr=0; rf_wdata=0; stall_req=0; starvation counter=0. A reset mid-operation loses in-flight secondary data; this is intended.
- Effective primary request: p_wen && p_waddr!=0. A primary write to x0 is dropped and does not use the port.
- Secondary accept: s_valid && s_ready at the clock edge.
  - s_waddr==0: handshake completes, nothing is enqueued.
  - Otherwise: push {s_waddr, s_wdata}.
  - s_ready is computed from occupancy before any same-cycle pop. When full, no push occurs even if a pop happens in that cycle.
- Arbitration, decided each cycle and registered onto rf_* at the edge (one-cycle latency):
  - Effective primary request: rf_wen<=1 with the primary addr/data. Primary always wins.
  - Else FIFO non-empty: rf_wen<=1 with the head; pop.
  - Else rf_wen<=0; rf_waddr/rf_wdata hold their last values.
- rfile write timing: otter_rfile writes on the edge ending the cycle in which rf_wen=1. Total primary latency to rfile contents is 2 edges.
- Ordering: the FIFO is strict in-order. Secondary data never bypasses rfile reads; readers wait on the scoreboard.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Resets to 0 on any pop, or when the FIFO is empty.
  - stall_req<=1 when the counter reaches STARVE_MAX-1 and the head is still blocked.
  - stall_req<=0 on the edge that pops an entry with the FIFO then empty, or on reset.
  - stall_req is advisory only. A primary write presented while it is high still wins.
- Scoreboard:
  - Set: issue_en && issue_rd!=0 sets busy[issue_rd] at the edge.
  - Clear: busy[r] clears at the edge where rf_wen=1, rf_waddr=r and the entry came from the secondary path. Track this with a registered rf_src_sec flag.
  - Set and clear of the same r at the same edge: set wins.
  - A primary write never clears busy bits.
  - The issuer guarantees at most one outstanding long-latency op per rd.
- chk_busy*: purely combinational from busy_vec. busy_vec[0] is tied to 0.

Test Plan:
- Reset, then an idle cycle -> rf_wen=0, busy_vec=0, s_ready=1, stall_req=0. Primary write x5=0x12345678 -> rf_wen=1, rf_waddr=5 on the next cycle; rfile x5 reads 0x12345678 one edge later.
- issue x10; secondary x10=0xDEADC0DE with p_wen low -> chk_busy1(10)=1 until the rf_wen cycle; after that edge chk_busy1=0 and rfile x10=0xDEADC0DE.
- Secondary pushes of x3=0xA, then x4=0xB, while p_wen is held high to x7 for 6 cycles:
  - s_ready=0 after 2 pushes.
  - stall_req=1 after STARVE_MAX blocked cycles.
  - On p_wen drop: x3 is written, then x4, in order; then stall_req=0.
- Same-edge issue x8 and secondary retire of an earlier x8 -> busy[8] remains 1.
- Primary write x0=0xDEADBEEF and secondary x0 -> rf_wen stays 0, FIFO stays empty, rfile x0 reads 0.
- Reset asserted with 2 FIFO entries and busy x12 -> next cycle: FIFO empty, busy_vec=0, rf_wen=0, and no write to x12 ever occurs.
